// File: rtl/window_buffer_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_buffer_ctrl_if : start/abort, RAM, window buffer and result port    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface window_buffer_ctrl_if #(
  parameter int DataBitWidth = 12,
  parameter int ImgWidth     = 64,
  parameter int ImgHeight    = 64,
  parameter int AddrWidth    = 12
);
  localparam int RowW = $clog2(ImgHeight);
  localparam int ColW = $clog2(ImgWidth);

  logic                    start;
  logic                    abort;
  logic                    busy;
  logic                    done;
  logic                    mem_rd_en;
  logic [AddrWidth-1:0]    mem_addr;
  logic [DataBitWidth-1:0] mem_rd_data;
  logic                    buf_rst;
  logic                    buf_en;
  logic [DataBitWidth-1:0] buf_d_in;
  logic [DataBitWidth-1:0] buf_d_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [DataBitWidth-1:0] out_data;
  logic [RowW-1:0]         out_row;
  logic [ColW-1:0]         out_col;

  modport master (
    input  start, abort, mem_rd_data, buf_d_out, out_ready,
    output busy, done, mem_rd_en, mem_addr, buf_rst, buf_en, buf_d_in,
           out_valid, out_data, out_row, out_col
  );

  modport slave (
    output start, abort, mem_rd_data, buf_d_out, out_ready,
    input  busy, done, mem_rd_en, mem_addr, buf_rst, buf_en, buf_d_in,
           out_valid, out_data, out_row, out_col
  );
endinterface
`default_nettype wire

// File: rtl/window_buffer_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | window_buffer_ctrl : 5x5 window sequencer, 5-row strips, column by column |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module window_buffer_ctrl #(
  parameter int DataBitWidth = 12,
  parameter int ImgWidth     = 64,
  parameter int ImgHeight    = 64,
  parameter int AddrWidth    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  window_buffer_ctrl_if.master bus
);
  localparam int RowW = $clog2(ImgHeight);
  localparam int ColW = $clog2(ImgWidth);
  localparam logic [ColW-1:0] LAST_COL  = ColW'(ImgWidth - 1);
  localparam logic [RowW-1:0] LAST_BASE = RowW'(ImgHeight - 5);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_CAPT  = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [RowW-1:0]         row_base_q, row_base_d;
  logic [ColW-1:0]         col_q, col_d;
  logic [2:0]              k_q, k_d;
  logic                    buf_en_q, buf_en_d;
  logic                    out_valid_q, out_valid_d;
  logic [DataBitWidth-1:0] out_data_q, out_data_d;
  logic [RowW-1:0]         out_row_q, out_row_d;
  logic [ColW-1:0]         out_col_q, out_col_d;
  logic                    rd_en;
  logic                    clr;
  logic                    done;
  logic [AddrWidth-1:0]    row_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_base_q  <= '0;
      col_q       <= '0;
      k_q         <= '0;
      buf_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_base_q  <= row_base_d;
      col_q       <= col_d;
      k_q         <= k_d;
      buf_en_q    <= buf_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_base_d  = row_base_q;
    col_d       = col_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    rd_en       = 1'b0;
    clr         = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr     = 1'b1;
        col_d   = '0;
        k_d     = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_en = 1'b1;
        if (k_q == 3'd4) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      S_DRAIN: begin
        // Until five columns are in the buffer there is no complete window.
        if (col_q >= ColW'(4)) begin
          state_d = S_CAPT;
        end else begin
          col_d   = col_q + ColW'(1);
          state_d = S_FETCH;
        end
      end
      S_CAPT: begin
        out_data_d  = bus.buf_d_out;
        out_row_d   = row_base_q + RowW'(2);
        out_col_d   = col_q - ColW'(2);
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (col_q != LAST_COL) begin
            col_d   = col_q + ColW'(1);
            state_d = S_FETCH;
          end else if (row_base_q < LAST_BASE) begin
            row_base_d = row_base_q + RowW'(1);
            state_d    = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        row_base_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything, including a same-cycle accept.
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      row_base_d  = '0;
      k_d         = '0;
      out_valid_d = 1'b0;
      rd_en       = 1'b0;
    end
  end

  assign buf_en_d = rd_en;
  assign row_idx  = AddrWidth'(row_base_q) + AddrWidth'(k_q);

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done;
  assign bus.mem_rd_en = rd_en;
  assign bus.mem_addr  = row_idx * AddrWidth'(ImgWidth) + AddrWidth'(col_q);
  assign bus.buf_rst   = rst | clr;
  assign bus.buf_en    = buf_en_q;
  assign bus.buf_d_in  = bus.mem_rd_data;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
endmodule
`default_nettype wire
